// File: rtl/fwd_ctrl_pkg.sv
// Shared types for the EXE-stage forwarding / load-stall controller.
package fwd_ctrl_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_DC  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } stg_t;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_DC_WAIT = 1'b1
  } state_t;

  localparam stg_t STG_BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

endpackage

// File: rtl/fwd_ctrl_if.sv
// Bundle between the core pipeline (master) and the forwarding controller (slave).
interface fwd_ctrl_if #(
  parameter int CNT_W = 16
);
  import fwd_ctrl_pkg::*;

  logic [REG_AW-1:0] rs1_ID;
  logic [REG_AW-1:0] rs2_ID;
  logic [REG_AW-1:0] rd_ID;
  logic              regwrite_ID;
  logic              memread_ID;
  logic              flush;
  logic              ext_stall;
  logic              dcache_ready;
  logic [1:0]        rs_sel;
  logic [1:0]        rt_sel;
  logic              stall;
  logic [CNT_W-1:0]  stall_cycles;
  state_t            state_dbg;
  stg_t              wb_dbg;

  // All signals are level-based per cycle; no valid/ready pairing: the ID
  // fields are taken on any cycle where neither stall nor ext_stall is high.
  modport master (
    output rs1_ID, rs2_ID, rd_ID, regwrite_ID, memread_ID, flush, ext_stall, dcache_ready,
    input  rs_sel, rt_sel, stall, stall_cycles, state_dbg, wb_dbg
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_ID, regwrite_ID, memread_ID, flush, ext_stall, dcache_ready,
    output rs_sel, rt_sel, stall, stall_cycles, state_dbg, wb_dbg
  );

endinterface

// File: rtl/fwd_ctrl_match.sv
// Priority compare of one ID source register against the EXE and MEM shadow entries.
module fwd_match
  import fwd_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  stg_t              e_i,
  input  logic [REG_AW-1:0] m_rd_i,
  input  logic              m_regwrite_i,
  output fwd_sel_t          sel_o
);

  // The younger producer in E wins over M; x0 never forwards.
  always_comb begin
    sel_o = FWD_RF;
    if (src_i == '0) begin
      sel_o = FWD_RF;
    end else if (e_i.regwrite && (e_i.rd == src_i)) begin
      sel_o = e_i.memread ? FWD_DC : FWD_MEM;
    end else if (m_regwrite_i && (m_rd_i == src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding select generation, D-cache load stall and stall-cycle counter.
module fwd_ctrl
  import fwd_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fwd_ctrl_if.slave   bus
);

  stg_t             e_q, e_d, m_q, w_q;
  state_t           state_q, state_d;
  fwd_sel_t         rs_sel_q, rs_sel_d, rt_sel_q, rt_sel_d;
  fwd_sel_t         rs_match, rt_match;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             m_load;
  logic             stall;
  logic             adv;

  assign m_load = m_q.memread && m_q.regwrite;

  fwd_match u_rs_match (
    .src_i        (bus.rs1_ID),
    .e_i          (e_q),
    .m_rd_i       (m_q.rd),
    .m_regwrite_i (m_q.regwrite),
    .sel_o        (rs_match)
  );

  fwd_match u_rt_match (
    .src_i        (bus.rs2_ID),
    .e_i          (e_q),
    .m_rd_i       (m_q.rd),
    .m_regwrite_i (m_q.regwrite),
    .sel_o        (rt_match)
  );

  // dcache_ready is used combinationally so the release cycle is not stalled.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = m_load && !bus.dcache_ready;
        if (stall) state_d = ST_DC_WAIT;
      end
      ST_DC_WAIT: begin
        stall = !bus.dcache_ready;
        if (bus.dcache_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign adv = !stall && !bus.ext_stall;

  always_comb begin
    e_d      = STG_BUBBLE;
    rs_sel_d = FWD_RF;
    rt_sel_d = FWD_RF;
    if (!bus.flush) begin
      e_d      = '{rd: bus.rd_ID, regwrite: bus.regwrite_ID, memread: bus.memread_ID};
      rs_sel_d = rs_match;
      rt_sel_d = rt_match;
    end
    cnt_d = cnt_q;
    if (stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      e_q      <= STG_BUBBLE;
      m_q      <= STG_BUBBLE;
      w_q      <= STG_BUBBLE;
      rs_sel_q <= FWD_RF;
      rt_sel_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (adv) begin
        e_q      <= e_d;
        m_q      <= e_q;
        w_q      <= m_q;
        rs_sel_q <= rs_sel_d;
        rt_sel_q <= rt_sel_d;
      end
    end
  end

  assign bus.rs_sel       = rs_sel_q;
  assign bus.rt_sel       = rt_sel_q;
  assign bus.stall        = stall;
  assign bus.stall_cycles = cnt_q;
  assign bus.state_dbg    = state_q;
  assign bus.wb_dbg       = w_q;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed test-plan steps plus random traffic against an instruction-history model.
module tb_fwd_ctrl;
  import fwd_ctrl_pkg::*;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } ins_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  fwd_ctrl_if #(.CNT_W(16)) bus ();
  fwd_ctrl_if #(.CNT_W(4))  bus4 ();

  fwd_ctrl #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  fwd_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  assign bus4.rs1_ID       = bus.rs1_ID;
  assign bus4.rs2_ID       = bus.rs2_ID;
  assign bus4.rd_ID        = bus.rd_ID;
  assign bus4.regwrite_ID  = bus.regwrite_ID;
  assign bus4.memread_ID   = bus.memread_ID;
  assign bus4.flush        = bus.flush;
  assign bus4.ext_stall    = bus.ext_stall;
  assign bus4.dcache_ready = bus.dcache_ready;

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  ins_t       hist[$];   // instructions that entered EXE, oldest first
  logic [1:0] exp_rs, exp_rt;
  int         exp_cnt;
  bit         exp_wait;
  bit         accepted;

  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_back('0);
    exp_rs   = 2'd0;
    exp_rt   = 2'd0;
    exp_cnt  = 0;
    exp_wait = 1'b0;
  endtask

  function automatic logic [1:0] sel_for(input logic [4:0] s);
    ins_t e = hist[hist.size()-1];
    ins_t m = hist[hist.size()-2];
    if (s == 5'd0) return 2'd0;
    if (e.wr && e.rd == s) return e.ld ? 2'd3 : 2'd1;
    if (m.wr && m.rd == s) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit m_is_load();
    ins_t m = hist[hist.size()-2];
    return m.wr && m.ld;
  endfunction

  function automatic logic [31:0] sat(input int v, input int lim);
    return (v > lim) ? 32'(lim) : 32'(v);
  endfunction

  function automatic logic [31:0] wkey(input logic [4:0] rd, input logic wr, input logic ld);
    return {25'd0, wr, ld, (wr ? rd : 5'd0)};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic cycle();
    bit   exp_stall;
    ins_t w;
    @(negedge clk);
    exp_stall = m_is_load() && !bus.dcache_ready;
    w = hist[hist.size()-3];
    check("stall",   32'(bus.stall),          32'(exp_stall));
    check("stall4",  32'(bus4.stall),         32'(exp_stall));
    check("rs_sel",  32'(bus.rs_sel),         32'(exp_rs));
    check("rt_sel",  32'(bus.rt_sel),         32'(exp_rt));
    check("cnt16",   32'(bus.stall_cycles),   sat(exp_cnt, 65535));
    check("cnt4",    32'(bus4.stall_cycles),  sat(exp_cnt, 15));
    check("state",   32'(bus.state_dbg),      exp_wait ? 32'(ST_DC_WAIT) : 32'(ST_RUN));
    check("wb",      wkey(bus.wb_dbg.rd, bus.wb_dbg.regwrite, bus.wb_dbg.memread), wkey(w.rd, w.wr, w.ld));
    accepted = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (exp_stall) exp_cnt++;
      exp_wait = exp_stall;
      if (!exp_stall && !bus.ext_stall) begin
        exp_rs = bus.flush ? 2'd0 : sel_for(bus.rs1_ID);
        exp_rt = bus.flush ? 2'd0 : sel_for(bus.rs2_ID);
        hist.push_back(bus.flush ? ins_t'('0) : ins_t'({bus.rd_ID, bus.regwrite_ID, bus.memread_ID}));
        void'(hist.pop_front());
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_id(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit wr, input bit ld, input bit fl);
    bus.rd_ID       = rd;
    bus.rs1_ID      = rs1;
    bus.rs2_ID      = rs2;
    bus.regwrite_ID = wr;
    bus.memread_ID  = ld;
    bus.flush       = fl;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit wr, input bit ld, input bit fl);
    int budget = 50;
    set_id(rd, rs1, rs2, wr, ld, fl);
    do begin
      cycle();
      budget--;
    end while (!accepted && budget > 0);
    check("issue_accept", 32'(accepted), 32'd1);
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ext_stall    = 1'b0;
    bus.dcache_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_rs",    32'(bus.rs_sel),       32'd0);
    check("rst_rt",    32'(bus.rt_sel),       32'd0);
    check("rst_stall", 32'(bus.stall),        32'd0);
    check("rst_cnt",   32'(bus.stall_cycles), 32'd0);
    check("rst_state", 32'(bus.state_dbg),    32'(ST_RUN));
    rst = 1'b0;

    // back-to-back ALU dependency
    issue(5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    issue(5'd8, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    check("b2b_rs", 32'(bus.rs_sel), 32'd1);
    check("b2b_rt", 32'(bus.rt_sel), 32'd0);

    // distance-2 dependency
    issue(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    issue(5'd10, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("d2_rt", 32'(bus.rt_sel), 32'd2);

    // x0 never forwards
    issue(5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    issue(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("x0_rs", 32'(bus.rs_sel), 32'd0);
    check("x0_rt", 32'(bus.rt_sel), 32'd0);

    // E beats M
    issue(5'd9, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    issue(5'd9, 5'd2, 5'd2, 1'b1, 1'b0, 1'b0);
    issue(5'd11, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
    check("prio_rs", 32'(bus.rs_sel), 32'd1);
    check("prio_rt", 32'(bus.rt_sel), 32'd1);

    // flush bubbles the dependent instruction
    issue(5'd12, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    issue(5'd13, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1);
    check("flush_rs", 32'(bus.rs_sel), 32'd0);
    issue(5'd14, 5'd13, 5'd12, 1'b1, 1'b0, 1'b0);
    check("flush_later_rs", 32'(bus.rs_sel), 32'd0);
    check("flush_later_rt", 32'(bus.rt_sel), 32'd2);

    // load-use with a 3-cycle D-cache miss
    do_reset();
    issue(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    issue(5'd4, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0);
    check("lu_rs", 32'(bus.rs_sel), 32'd3);
    bus.dcache_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("lu_stall", 32'(bus.stall),  32'd1);
      check("lu_hold",  32'(bus.rs_sel), 32'd3);
      cycle();
    end
    bus.dcache_ready = 1'b1;
    #1;
    check("lu_release", 32'(bus.stall),        32'd0);
    check("lu_cnt",     32'(bus.stall_cycles), 32'd3);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 6) == 0));
      bus.ext_stall    = 1'($urandom_range(0, 6) == 0);
      bus.dcache_ready = 1'($urandom_range(0, 3) != 0);
      cycle();
    end
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.ext_stall    = 1'b0;
    bus.dcache_ready = 1'b1;

    // counter saturation on the narrow instance, with overlapping ext_stall
    do_reset();
    issue(5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0);
    issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.dcache_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.ext_stall = (i % 4 == 1);
      cycle();
    end
    bus.ext_stall = 1'b0;
    check("sat_cnt4",  32'(bus4.stall_cycles), 32'd15);
    check("sat_cnt16", 32'(bus.stall_cycles),  32'd20);

    // reset in the middle of a stall
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_rs",    32'(bus.rs_sel),        32'd0);
    check("mid_rst_rt",    32'(bus.rt_sel),        32'd0);
    check("mid_rst_stall", 32'(bus.stall),         32'd0);
    check("mid_rst_cnt",   32'(bus.stall_cycles),  32'd0);
    check("mid_rst_cnt4",  32'(bus4.stall_cycles), 32'd0);
    bus.dcache_ready = 1'b1;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
